// File: rtl/raiden_pkg.sv
// raiden_pkg: definitions shared by the Raiden sequencing controller, the
// control unit and the IO block.
//   exec_state_t        - execution controller FSM encoding (drives LEDs)
//   HALT_OPCODE_DEFAULT - opcode that stops execution
//   IO_OP_*             - io_op field values produced by the control unit
package raiden_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_HALTED  = 3'd3
    } exec_state_t;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

    localparam logic [3:0] IO_OP_NONE = 4'd0;
    localparam logic [3:0] IO_OP_IN   = 4'd1;
    localparam logic [3:0] IO_OP_OUT  = 4'd2;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous, already-debounced button level into the
// clock domain and turns each rising edge into a one-cycle pulse.
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   pin   - debounced button level (asynchronous to clock)
//   pulse - registered one-cycle pulse, high two edges after pin is first
//           sampled high
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_1    <= pin;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            pulse     <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/exec_controller.sv
// exec_controller: sequences the single-cycle Raiden datapath from a
// free-running clock. Provides RUN, single STEP, input wait and HALT, and
// counts retired instructions.
// Ports:
//   clock         - system clock
//   reset         - asynchronous active-low reset
//   run_sw        - level, 1 selects continuous RUN
//   step_btn      - debounced level, rising edge requests one instruction
//   confirm_btn   - debounced level, rising edge releases an input wait
//   restart_btn   - debounced level, rising edge restarts the program
//   opcode        - opcode of the currently fetched instruction
//   io_op         - IO control of the current instruction
//   cpu_en        - one-cycle commit enable for PC, register bank, data memory
//   pc_clear      - one-cycle synchronous PC clear
//   waiting_input - high while in WAIT_IN
//   halted        - high while in HALTED
//   state         - FSM state encoding (LEDs / debug)
//   instr_count   - retired instruction count, saturating
//
// cpu_en is a strobe with no ready: the datapath always commits on the edge
// where cpu_en=1, and the next opcode is valid in the following cycle.
module exec_controller
    import raiden_pkg::*;
#(
    parameter int unsigned RUN_DIV     = 4,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
    parameter logic [3:0]  IO_IN_OP    = IO_OP_IN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        confirm_btn,
    input  logic        restart_btn,
    input  logic [5:0]  opcode,
    input  logic [3:0]  io_op,
    output logic        cpu_en,
    output logic        pc_clear,
    output logic        waiting_input,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(RUN_DIV - 1);

    logic step_pulse;
    logic confirm_pulse;
    logic restart_pulse;

    edge_sync u_step_sync (
        .clock (clock),
        .reset (reset),
        .pin   (step_btn),
        .pulse (step_pulse)
    );

    edge_sync u_confirm_sync (
        .clock (clock),
        .reset (reset),
        .pin   (confirm_btn),
        .pulse (confirm_pulse)
    );

    edge_sync u_restart_sync (
        .clock (clock),
        .reset (reset),
        .pin   (restart_btn),
        .pulse (restart_pulse)
    );

    exec_state_t      state_q,    state_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             cpu_en_q,   cpu_en_d;
    logic             pc_clear_q, pc_clear_d;
    logic             waiting_q,  waiting_d;
    logic             halted_q,   halted_d;
    logic [15:0]      count_q,    count_d;
    logic             issue_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            cpu_en_q   <= 1'b0;
            pc_clear_q <= 1'b0;
            waiting_q  <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cpu_en_q   <= cpu_en_d;
            pc_clear_q <= pc_clear_d;
            waiting_q  <= waiting_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cpu_en_d   = 1'b0;
        pc_clear_d = 1'b0;
        issue_req  = 1'b0;
        // The instruction retires on the edge where cpu_en_q is high.
        count_d    = (cpu_en_q && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;

        if (restart_pulse) begin
            pc_clear_d = 1'b1;
            count_d    = '0;
            state_d    = ST_IDLE;
            div_d      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_sw) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end else if (step_pulse) begin
                        issue_req = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_sw) begin
                        state_d = ST_IDLE;
                        div_d   = '0;
                    end else if (div_q == DIV_TERM) begin
                        div_d     = '0;
                        issue_req = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_WAIT_IN: begin
                    // The waiting instruction is known to be IO, so it
                    // commits without repeating the HALT/IO checks.
                    if (confirm_pulse) begin
                        cpu_en_d = 1'b1;
                        div_d    = '0;
                        state_d  = run_sw ? ST_RUN : ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end
            endcase

            // Issue check: HALT and keyboard-input instructions never
            // commit directly from IDLE or RUN.
            if (issue_req) begin
                if (opcode == HALT_OPCODE) begin
                    state_d = ST_HALTED;
                end else if (io_op == IO_IN_OP) begin
                    state_d = ST_WAIT_IN;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
        end

        waiting_d = (state_d == ST_WAIT_IN);
        halted_d  = (state_d == ST_HALTED);
    end

    assign cpu_en        = cpu_en_q;
    assign pc_clear      = pc_clear_q;
    assign waiting_input = waiting_q;
    assign halted        = halted_q;
    assign state         = state_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: directed scenarios followed by random button,
// switch and opcode activity, checked every cycle against a behavioural
// model that works in terms of button events, a countdown to the next RUN
// issue and an instruction tally.
module tb_exec_controller;

    localparam int TB_RUN_DIV = 4;
    localparam logic [5:0] TB_HALT = 6'b111111;

    // model modes, numbered as the state output reports them
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_WAIT = 2;
    localparam int MODE_HALT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        confirm_btn = 1'b0;
    logic        restart_btn = 1'b0;
    logic [5:0]  opcode = '0;
    logic [3:0]  io_op = '0;
    logic        cpu_en;
    logic        pc_clear;
    logic        waiting_input;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] instr_count;

    exec_controller #(
        .RUN_DIV     (TB_RUN_DIV),
        .HALT_OPCODE (TB_HALT),
        .IO_IN_OP    (4'd1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run_sw        (run_sw),
        .step_btn      (step_btn),
        .confirm_btn   (confirm_btn),
        .restart_btn   (restart_btn),
        .opcode        (opcode),
        .io_op         (io_op),
        .cpu_en        (cpu_en),
        .pc_clear      (pc_clear),
        .waiting_input (waiting_input),
        .halted        (halted),
        .state         (state),
        .instr_count   (instr_count)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_clr = 0;

    // scoreboard: cycle numbers at which a commit strobe is expected
    logic [31:0] exp_q[$];

    // model state
    logic [4:0]  h_step, h_conf, h_rst;
    int          m_mode;
    int          m_left;
    logic        m_cpu;
    logic        m_pcclr;
    logic [15:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        h_step  = '0;
        h_conf  = '0;
        h_rst   = '0;
        m_mode  = MODE_IDLE;
        m_left  = TB_RUN_DIV;
        m_cpu   = 1'b0;
        m_pcclr = 1'b0;
        m_count = '0;
        exp_q.delete();
    endtask

    // An instruction that reaches the front of the pipeline is either
    // committed, parked for input, or stops the machine.
    task automatic model_issue(input logic from_confirm);
        if (opcode == TB_HALT)
            m_mode = MODE_HALT;
        else if (io_op == 4'd1 && !from_confirm)
            m_mode = MODE_WAIT;
        else
            m_cpu = 1'b1;
    endtask

    // One clock: advance the model at the rising edge, compare at the
    // falling edge.
    task automatic tick();
        logic step_ev, conf_ev, rst_ev, prev_cpu;
        @(posedge clock);
        cyc++;
        // a press first sampled at edge t takes effect at edge t+3
        h_step = {h_step[3:0], step_btn};
        h_conf = {h_conf[3:0], confirm_btn};
        h_rst  = {h_rst[3:0],  restart_btn};
        step_ev = h_step[3] & ~h_step[4];
        conf_ev = h_conf[3] & ~h_conf[4];
        rst_ev  = h_rst[3]  & ~h_rst[4];

        prev_cpu = m_cpu;
        m_cpu    = 1'b0;
        m_pcclr  = 1'b0;
        if (rst_ev) begin
            m_pcclr = 1'b1;
            m_count = '0;
            m_mode  = MODE_IDLE;
        end else begin
            if (prev_cpu && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            case (m_mode)
                MODE_IDLE: begin
                    if (run_sw) begin
                        m_mode = MODE_RUN;
                        m_left = TB_RUN_DIV;
                    end else if (step_ev) begin
                        model_issue(1'b0);
                    end
                end
                MODE_RUN: begin
                    if (!run_sw) begin
                        m_mode = MODE_IDLE;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_left = TB_RUN_DIV;
                            model_issue(1'b0);
                        end
                    end
                end
                MODE_WAIT: begin
                    if (conf_ev) begin
                        m_cpu  = 1'b1;
                        m_mode = run_sw ? MODE_RUN : MODE_IDLE;
                        m_left = TB_RUN_DIV;
                    end
                end
                default: ;
            endcase
        end
        if (m_cpu) exp_q.push_back(32'(cyc));

        @(negedge clock);
        check("cpu_en", 32'(cpu_en), 32'(m_cpu));
        check("pc_clear", 32'(pc_clear), 32'(m_pcclr));
        check("state", 32'(state), 32'(m_mode));
        check("waiting_input", 32'(waiting_input), 32'(m_mode == MODE_WAIT));
        check("halted", 32'(halted), 32'(m_mode == MODE_HALT));
        check("instr_count", 32'(instr_count), 32'(m_count));
        if (cpu_en) begin
            n_pulse++;
            if (exp_q.size() > 0)
                check("commit_cycle", 32'(cyc), exp_q.pop_front());
            else
                check("commit_spurious", 32'(cpu_en), 32'd0);
        end
        if (pc_clear) n_clr++;
    endtask

    task automatic press(input int which, input int hold);
        case (which)
            0: step_btn    = 1'b1;
            1: confirm_btn = 1'b1;
            default: restart_btn = 1'b1;
        endcase
        repeat (hold) tick();
        case (which)
            0: step_btn    = 1'b0;
            1: confirm_btn = 1'b0;
            default: restart_btn = 1'b0;
        endcase
        repeat (5) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_pc_clear"}, 32'(pc_clear), 32'd0);
        check({tag, "_waiting"}, 32'(waiting_input), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_count"}, 32'(instr_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // three single steps from IDLE
        for (int i = 0; i < 3; i++) press(0, $urandom_range(1, 3));
        check("step_count", 32'(instr_count), 32'd3);

        // continuous RUN: five strobes in the first 21 cycles after the switch
        n_pulse = 0;
        run_sw = 1'b1;
        repeat (21) tick();
        check("run_pulses", 32'(n_pulse), 32'd5);

        // keyboard input parks the machine until confirm
        io_op = 4'd1;
        repeat (6) tick();
        check("wait_state", 32'(state), 32'd2);
        check("wait_flag", 32'(waiting_input), 32'd1);
        n_pulse = 0;
        confirm_btn = 1'b1;
        repeat (2) tick();
        confirm_btn = 1'b0;
        io_op = 4'd0;
        repeat (10) tick();
        check("confirm_pulses", 32'(n_pulse), 32'd3);

        // HALT opcode stops everything but restart
        opcode = TB_HALT;
        repeat (6) tick();
        check("halt_state", 32'(state), 32'd3);
        n_pulse = 0;
        press(0, 2);
        press(1, 2);
        run_sw = 1'b0;
        repeat (3) tick();
        run_sw = 1'b1;
        repeat (3) tick();
        check("halt_no_commit", 32'(n_pulse), 32'd0);
        check("halt_held", 32'(halted), 32'd1);

        // restart from HALTED
        run_sw = 1'b0;
        opcode = 6'd0;
        n_clr = 0;
        press(2, 3);
        check("restart_clr_pulses", 32'(n_clr), 32'd1);
        check("restart_state", 32'(state), 32'd0);
        check("restart_count", 32'(instr_count), 32'd0);

        // saturation of the retired-instruction counter
        force dut.count_q = 16'hFFFE;
        m_count = 16'hFFFE;
        tick();
        release dut.count_q;
        for (int i = 0; i < 3; i++) press(0, 2);
        check("count_saturated", 32'(instr_count), 32'hFFFF);

        // asynchronous reset in the middle of RUN
        run_sw = 1'b1;
        repeat (7) tick();
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        run_sw = 1'b0;
        @(negedge clock);
        check_all_zero("reset_held");
        model_reset();
        reset = 1'b1;

        // random activity
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 4) == 0) confirm_btn = ~confirm_btn;
            if ($urandom_range(0, 59) == 0) restart_btn = ~restart_btn;
            if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 29) == 0)
                opcode = TB_HALT;
            else
                opcode = 6'($urandom_range(0, 62));
            if ($urandom_range(0, 7) == 0)
                io_op = 4'd1;
            else
                io_op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(2, 15));
            tick();
        end

        step_btn = 1'b0;
        confirm_btn = 1'b0;
        restart_btn = 1'b0;
        repeat (8) tick();
        check("commit_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
# exec_controller

Sequencing controller for the single-cycle Raiden datapath. The datapath currently advances once per debounced button press. This block replaces that scheme with a free-running system clock and a one-cycle commit enable (`cpu_en`). It provides RUN, single-STEP, input-wait and HALT behaviour, detects HALT and keyboard-input instructions from the fetched opcode, and counts retired instructions. It sits between the board controls and the datapath's PC, register bank and data memory write enables.

## Interface
Parameters:
- `RUN_DIV`, 4: system-clock cycles between commits in RUN mode; minimum 2.
- `HALT_OPCODE`, 6'b111111: opcode that stops execution.
- `IO_IN_OP`, 4'd1: `io_op` value meaning "read keys".

Ports:
- `clock`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run_sw`  in  1  level; 1 selects continuous RUN.
- `step_btn`  in  1  debounced level; a rising edge requests one instruction.
- `confirm_btn`  in  1  debounced level; a rising edge releases an input wait.
- `restart_btn`  in  1  debounced level; a rising edge restarts the program.
- `opcode`  in  6  opcode of the currently fetched instruction (combinational from instruction memory).
- `io_op`  in  4  IO control of the current instruction, from the control unit.
- `cpu_en`  out  1  one-cycle commit enable for PC, register bank and data memory.
- `pc_clear`  out  1  one-cycle synchronous PC clear.
- `waiting_input`  out  1  high while in WAIT_IN.
- `halted`  out  1  high while in HALTED.
- `state`  out  3  encoded FSM state, for LEDs and debug.
- `instr_count`  out  16  number of retired instructions.

## Operation
- Button inputs pass through a 2-FF synchroniser, then a rising-edge detector. Each detector output is a one-cycle pulse.
- FSM states: IDLE(0), RUN(1), WAIT_IN(2), HALTED(3).
- Issue check: before any `cpu_en` pulse, the FSM inspects the current `opcode` and `io_op`.
  - If `opcode == HALT_OPCODE`: go to HALTED, no pulse.
  - Else if `io_op == IO_IN_OP` and the issue was not triggered by `confirm_btn`: go to WAIT_IN, no pulse.
  - Otherwise: pulse `cpu_en`.
- IDLE:
  - `run_sw=1` → RUN, with the divider cleared.
  - Step edge (only while `run_sw=0`) → issue check. On success, stay in IDLE.
- RUN:
  - The divider counts 0..`RUN_DIV`-1. At terminal count the FSM performs the issue check and the divider wraps to 0.
  - `run_sw=0` → IDLE. The divider clears and no pulse is issued that cycle.
  - Step edges are ignored.
- WAIT_IN:
  - Confirm edge → `cpu_en` pulse, bypassing the IO check. The HALT check cannot match here, because the instruction is already known to be IO.
  - The FSM then returns to RUN if `run_sw=1`, else to IDLE. On return to RUN the divider clears.
- HALTED: ignores `run_sw`, `step_btn` and `confirm_btn`.
- Restart edge (any state, highest priority):
  - One-cycle `pc_clear` pulse.
  - `instr_count` cleared, FSM → IDLE, divider cleared.
  - No `cpu_en` that cycle.
- `instr_count` increments on every `cpu_en` pulse and saturates at 16'hFFFF.

## Timing
- Reset values: `cpu_en=0`, `pc_clear=0`, `waiting_input=0`, `halted=0`, `state=0`, `instr_count=0`, divider 0, synchroniser and edge flops 0.
- All outputs are registered.
- Button latency: if the pin is first sampled high on edge t, the edge pulse is internal on t+2 and `cpu_en` or `pc_clear` is high during the cycle after t+3.
- `cpu_en` is high for exactly one cycle, and never in two consecutive cycles.
- The datapath commits on the clock edge where `cpu_en=1`. The new `opcode` is valid the following cycle. `RUN_DIV>=2` guarantees the issue check never sees a stale opcode.
- RUN steady state: one `cpu_en` every `RUN_DIV` cycles. The first pulse comes `RUN_DIV` cycles after entering RUN.
- `waiting_input` and `halted` assert in the same cycle that `state` changes.

## Structure
- Shared package `raiden_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_RUN`, `ST_WAIT_IN`, `ST_HALTED`;
  - the default `HALT_OPCODE`;
  - the IO operation codes, shared with the control unit and the IO block.
- One sub-module, `edge_sync`: 2-FF synchroniser plus rising-edge pulse. It is instantiated three times.

## Test plan
- Reset, `run_sw=0`, `opcode=0`, `io_op=0`, then 3 step presses → exactly 3 single-cycle `cpu_en` pulses, each 3 cycles after its press; `instr_count=3`.
- `run_sw=1`, `RUN_DIV=4`, 20 cycles of ordinary opcodes → `cpu_en` on cycles 4, 8, 12, 16, 20 after entering RUN; `instr_count=5`.
- In RUN, `io_op` becomes 1 → `waiting_input=1` and `state=2` with no pulse. Confirm press → one `cpu_en`, back to RUN, next pulse `RUN_DIV` cycles later.
- `opcode=6'b111111` in RUN → `halted=1`, `state=3`. Further step, confirm and `run_sw` toggles produce no `cpu_en`.
- Restart press while HALTED with `instr_count=7` → `pc_clear` for one cycle, `instr_count=0`, `state=0`.
- Counter preloaded to 16'hFFFE plus 3 steps → `instr_count` holds at 16'hFFFF. Asserting `reset` mid-RUN clears all outputs immediately (asynchronous).
